// File: rtl/alu_issue_arbiter.sv
// rtl/alu_issue_arbiter.sv - round-robin/lockable issue arbiter and 2-stage pipe for the shared execute ALU
// Optional performance counters: `define ALU_ARB_PERF_EN
module alu_issue_arbiter #(
   parameter int                  DST_W       = 4,
   parameter int                  PERF_W      = 32,
   parameter int                  OPCODE_W    = 6,
   parameter int                  REG_W       = 64,
   parameter int                  IMM_W       = 32,
   parameter int                  BIT_MODE_W  = 2,
   parameter logic [OPCODE_W:0]   NUM_ALU_OPS = (OPCODE_W+1)'(8),
   parameter logic [OPCODE_W-1:0] MICRO_MOV   = OPCODE_W'(3),
   parameter logic [OPCODE_W-1:0] MICRO_MOVI  = OPCODE_W'(4)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  flush,
   input  logic                  req0_valid,
   output logic                  req0_ready,
   input  logic                  req0_lock,
   input  logic [OPCODE_W-1:0]   req0_opcode,
   input  logic [REG_W-1:0]      req0_s,
   input  logic [REG_W-1:0]      req0_t,
   input  logic [IMM_W-1:0]      req0_imm,
   input  logic [BIT_MODE_W-1:0] req0_bit_mode,
   input  logic [DST_W-1:0]      req0_dst,
   input  logic                  req1_valid,
   output logic                  req1_ready,
   input  logic                  req1_lock,
   input  logic [OPCODE_W-1:0]   req1_opcode,
   input  logic [REG_W-1:0]      req1_s,
   input  logic [REG_W-1:0]      req1_t,
   input  logic [IMM_W-1:0]      req1_imm,
   input  logic [BIT_MODE_W-1:0] req1_bit_mode,
   input  logic [DST_W-1:0]      req1_dst,
   output logic [OPCODE_W-1:0]   alu_opcode,
   output logic [REG_W-1:0]      alu_s,
   output logic [REG_W-1:0]      alu_t,
   output logic [IMM_W-1:0]      alu_imm,
   output logic [BIT_MODE_W-1:0] alu_bit_mode,
   output logic [REG_W-1:0]      alu_eflags_as_src,
   input  logic [REG_W-1:0]      alu_d,
   input  logic [REG_W-1:0]      alu_eflags,
   output logic                  res_valid,
   input  logic                  res_ready,
   output logic [REG_W-1:0]      res_d,
   output logic [DST_W-1:0]      res_dst,
   output logic                  res_src,
   output logic [REG_W-1:0]      eflags_q,
   output logic [PERF_W-1:0]     perf_grant0,
   output logic [PERF_W-1:0]     perf_grant1,
   output logic [PERF_W-1:0]     perf_stall
);

   localparam logic [REG_W-1:0] EFLAGS_RST = {{(REG_W-2){1'b0}}, 2'b10};

   logic                  r_iss_v;
   logic [OPCODE_W-1:0]   r_iss_op;
   logic [REG_W-1:0]      r_iss_s;
   logic [REG_W-1:0]      r_iss_t;
   logic [IMM_W-1:0]      r_iss_imm;
   logic [BIT_MODE_W-1:0] r_iss_bm;
   logic [DST_W-1:0]      r_iss_dst;
   logic                  r_iss_src;
   logic                  r_res_v;
   logic [REG_W-1:0]      r_res_d;
   logic [DST_W-1:0]      r_res_dst;
   logic                  r_res_src;
   logic [REG_W-1:0]      r_eflags;
   logic                  r_rr_ptr;
   logic                  r_lock_v;
   logic                  r_lock_owner;

   logic w_adv_res, w_can_issue, w_elig0, w_elig1, w_pick1, w_grant, w_flags_upd;

   assign w_adv_res   = r_iss_v & (~r_res_v | res_ready);
   assign w_can_issue = ~r_iss_v | w_adv_res;
   assign w_elig0     = req0_valid & (~r_lock_v | ~r_lock_owner);
   assign w_elig1     = req1_valid & (~r_lock_v |  r_lock_owner);
   // r_rr_ptr names the preferred requester; the other wins only if it is the sole eligible one
   assign w_pick1     = r_rr_ptr ? w_elig1 : ~w_elig0;
   assign w_grant     = w_can_issue & ~flush & (w_elig0 | w_elig1);
   assign req0_ready  = w_grant & ~w_pick1;
   assign req1_ready  = w_grant &  w_pick1;

   assign w_flags_upd = ({1'b0, r_iss_op} < NUM_ALU_OPS) &
                        (r_iss_op != MICRO_MOV) & (r_iss_op != MICRO_MOVI);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_iss_v      <= 1'b0;
         r_iss_op     <= '0;
         r_iss_s      <= '0;
         r_iss_t      <= '0;
         r_iss_imm    <= '0;
         r_iss_bm     <= '0;
         r_iss_dst    <= '0;
         r_iss_src    <= 1'b0;
         r_res_v      <= 1'b0;
         r_res_d      <= '0;
         r_res_dst    <= '0;
         r_res_src    <= 1'b0;
         r_eflags     <= EFLAGS_RST;
         r_rr_ptr     <= 1'b0;
         r_lock_v     <= 1'b0;
         r_lock_owner <= 1'b0;
      end else if (flush) begin
         r_iss_v  <= 1'b0;
         r_res_v  <= 1'b0;
         r_lock_v <= 1'b0;
      end else begin
         if (w_grant) begin
            r_iss_v      <= 1'b1;
            r_iss_op     <= w_pick1 ? req1_opcode   : req0_opcode;
            r_iss_s      <= w_pick1 ? req1_s        : req0_s;
            r_iss_t      <= w_pick1 ? req1_t        : req0_t;
            r_iss_imm    <= w_pick1 ? req1_imm      : req0_imm;
            r_iss_bm     <= w_pick1 ? req1_bit_mode : req0_bit_mode;
            r_iss_dst    <= w_pick1 ? req1_dst      : req0_dst;
            r_iss_src    <= w_pick1;
            r_rr_ptr     <= ~w_pick1;
            r_lock_v     <= w_pick1 ? req1_lock : req0_lock;
            r_lock_owner <= w_pick1;
         end else if (w_adv_res) begin
            r_iss_v <= 1'b0;
         end
         if (w_adv_res) begin
            r_res_v   <= 1'b1;
            r_res_d   <= alu_d;
            r_res_dst <= r_iss_dst;
            r_res_src <= r_iss_src;
            if (w_flags_upd) r_eflags <= alu_eflags;
         end else if (res_ready) begin
            r_res_v <= 1'b0;
         end
      end
   end

   assign alu_opcode        = r_iss_v ? r_iss_op  : '0;
   assign alu_s             = r_iss_v ? r_iss_s   : '0;
   assign alu_t             = r_iss_v ? r_iss_t   : '0;
   assign alu_imm           = r_iss_v ? r_iss_imm : '0;
   assign alu_bit_mode      = r_iss_v ? r_iss_bm  : '0;
   assign alu_eflags_as_src = r_eflags;
   assign eflags_q          = r_eflags;
   assign res_valid         = r_res_v;
   assign res_d             = r_res_d;
   assign res_dst           = r_res_dst;
   assign res_src           = r_res_src;

`ifdef ALU_ARB_PERF_EN
   logic [PERF_W-1:0] r_perf_g0, r_perf_g1, r_perf_stall;
   logic              w_stall;

   assign w_stall = (req0_valid | req1_valid) & ~(req0_ready | req1_ready);

   // Saturating counters; flush deliberately has no effect on them
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_perf_g0    <= '0;
         r_perf_g1    <= '0;
         r_perf_stall <= '0;
      end else begin
         if (req0_ready && req0_valid && r_perf_g0 != '1) r_perf_g0 <= r_perf_g0 + 1'b1;
         if (req1_ready && req1_valid && r_perf_g1 != '1) r_perf_g1 <= r_perf_g1 + 1'b1;
         if (w_stall && r_perf_stall != '1) r_perf_stall <= r_perf_stall + 1'b1;
      end
   end

   assign perf_grant0 = r_perf_g0;
   assign perf_grant1 = r_perf_g1;
   assign perf_stall  = r_perf_stall;
`else
   assign perf_grant0 = '0;
   assign perf_grant1 = '0;
   assign perf_stall  = '0;
`endif

endmodule
